// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - credit-limited instruction fetch unit with bundle queue and redirect flush
module fetch_buffer #(
    parameter int ISSUE_W = 2,
    parameter int DEPTH = 4,
    parameter int PC_W = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req_valid,
    output logic [PC_W-1:0]           imem_req_addr,
    input  logic                      imem_req_ready,
    input  logic                      imem_rsp_valid,
    input  logic [32*ISSUE_W-1:0]     imem_rsp_data,
    input  logic                      redirect_valid,
    input  logic [PC_W-1:0]           redirect_pc,
    output logic                      out_valid,
    output logic [32*ISSUE_W-1:0]     out_instr,
    output logic [ISSUE_W-1:0]        out_mask,
    output logic [PC_W-1:0]           out_pc,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int OFF_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0] LANE_MASK = PC_W'(ISSUE_W - 1);
    localparam logic [PC_W-1:0] STEP = PC_W'(ISSUE_W);
    localparam logic [PC_W-1:0] RESET_ALIGNED = RESET_PC & ~LANE_MASK;

    logic [PC_W-1:0]        fetch_pc;
    logic [PC_W-1:0]        rsp_pc;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W-1:0]       kill;
    logic                   first_pend;
    logic [OFF_W-1:0]       first_off;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;

    logic [32*ISSUE_W-1:0]  data_q [DEPTH];
    logic [ISSUE_W-1:0]     mask_q [DEPTH];
    logic [PC_W-1:0]        pc_q   [DEPTH];

    logic [CNT_W:0]         used;
    logic                   req_fire;
    logic                   rsp_take;
    logic                   enq;
    logic                   drop;
    logic                   pop;
    logic [ISSUE_W-1:0]     first_mask;
    logic [ISSUE_W-1:0]     enq_mask;
    logic [OFF_W-1:0]       redirect_off;
    logic [PC_W-1:0]        redirect_aligned;

    // Credits cover both queued bundles and requests still in memory, so an enqueue always has room.
    assign used           = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = rst_n && !redirect_valid && (used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take = imem_rsp_valid && (inflight != '0);
    assign enq      = rsp_take && !redirect_valid && (kill == '0);
    assign drop     = rsp_take && !redirect_valid && (kill != '0);
    assign pop      = out_valid && out_ready && !redirect_valid;

    assign redirect_off     = OFF_W'(redirect_pc & LANE_MASK);
    assign redirect_aligned = redirect_pc & ~LANE_MASK;

    always_comb begin
        first_mask = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            first_mask[i] = (i >= int'(first_off));
        end
    end

    assign enq_mask = first_pend ? first_mask : '1;

    assign out_valid = (count != '0);
    assign out_instr = data_q[head];
    assign out_mask  = mask_q[head];
    assign out_pc    = pc_q[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_ALIGNED;
            rsp_pc     <= RESET_ALIGNED;
            inflight   <= '0;
            kill       <= '0;
            first_pend <= 1'b0;
            first_off  <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else if (redirect_valid) begin
            // Everything still in memory belongs to the old path; a response landing now is dropped too.
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            inflight   <= inflight - CNT_W'(rsp_take);
            kill       <= inflight - CNT_W'(rsp_take);
            fetch_pc   <= redirect_aligned;
            rsp_pc     <= redirect_aligned;
            first_off  <= redirect_off;
            first_pend <= 1'b1;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (drop) begin
                kill <= kill - CNT_W'(1);
            end
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            // Live responses arrive in order from the last redirect target, so their pc is a running count.
            if (enq) begin
                tail       <= tail + PTR_W'(1);
                rsp_pc     <= rsp_pc + STEP;
                first_pend <= 1'b0;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_q[tail] <= imem_rsp_data;
            mask_q[tail] <= enq_mask;
            pc_q[tail]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer with memory model and queue-based reference
module tb_fetch_buffer;
    localparam int W = 2;
    localparam int DEPTH = 4;
    localparam int PC_W = 12;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  imem_req_valid;
    logic [PC_W-1:0]       imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [32*W-1:0]       imem_rsp_data;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;
    logic                  out_valid;
    logic [32*W-1:0]       out_instr;
    logic [W-1:0]          out_mask;
    logic [PC_W-1:0]       out_pc;
    logic                  out_ready;
    logic [$clog2(DEPTH):0] count;

    fetch_buffer #(.ISSUE_W(W), .DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_mask(out_mask), .out_pc(out_pc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned addr; int unsigned due; } mreq_t;
    typedef struct { int unsigned addr; bit stale; } ost_t;
    typedef struct { int unsigned pc; int unsigned mask; } bund_t;
    typedef struct { logic [11:0] rpc; logic [11:0] pc0; logic [1:0] m0; logic [11:0] pc1; } rd_vec_t;

    mreq_t mem_q[$];
    ost_t  ost[$];
    bund_t mq[$];
    bund_t popped[$];
    rd_vec_t tbl[5];

    int unsigned m_fetch_pc, m_first_off, cyc, n_acc, fix_lat;
    bit m_first_pend, rand_lat;
    bit drv_redirect, drv_out_ready, drv_req_ready;
    logic [PC_W-1:0] drv_rpc;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32*W-1:0] bdata(input int unsigned a);
        logic [32*W-1:0] d;
        for (int i = 0; i < W; i++) d[32*i +: 32] = 32'hA500_0000 | ((a + i) % 4096);
        return d;
    endfunction

    task automatic reset_model();
        mem_q.delete(); ost.delete(); mq.delete();
        m_fetch_pc = 0; m_first_pend = 0; m_first_off = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    // One clock: drive at posedge+1, compare and advance the model at negedge.
    task automatic step();
        bit exp_req, rsp;
        mreq_t r;
        ost_t e;
        bund_t b;
        int unsigned m;
        redirect_valid = drv_redirect;
        redirect_pc = drv_rpc;
        out_ready = drv_out_ready;
        imem_req_ready = drv_req_ready;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = bdata(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
        end
        @(negedge clk);
        exp_req = (ost.size() + mq.size() < DEPTH) && !drv_redirect;
        chk("req_valid", 128'(imem_req_valid), 128'(exp_req));
        if (exp_req) chk("req_addr", 128'(imem_req_addr), 128'(m_fetch_pc));
        chk("count", 128'(count), 128'(mq.size()));
        chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 128'(out_pc), 128'(mq[0].pc));
            chk("out_mask", 128'(out_mask), 128'(mq[0].mask));
            chk("out_instr", 128'(out_instr), 128'(bdata(mq[0].pc)));
        end
        if (out_valid && out_ready && !redirect_valid) begin
            b.pc = 32'(out_pc); b.mask = 32'(out_mask);
            popped.push_back(b);
        end
        rsp = imem_rsp_valid;
        if (rsp) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            r.addr = 32'(imem_req_addr);
            r.due = cyc + (rand_lat ? $urandom_range(1, 4) : fix_lat);
            mem_q.push_back(r);
            n_acc++;
        end
        if (drv_redirect) begin
            mq.delete();
            if (rsp && ost.size() > 0) void'(ost.pop_front());
            foreach (ost[i]) ost[i].stale = 1'b1;
            m_fetch_pc = (32'(drv_rpc) / W) * W;
            m_first_off = 32'(drv_rpc) % W;
            m_first_pend = 1'b1;
        end else begin
            if (mq.size() != 0 && drv_out_ready) void'(mq.pop_front());
            if (rsp && ost.size() > 0) begin
                e = ost.pop_front();
                if (!e.stale) begin
                    m = 0;
                    for (int i = 0; i < W; i++)
                        if (!m_first_pend || i >= int'(m_first_off)) m |= (32'd1 << i);
                    m_first_pend = 1'b0;
                    b.pc = e.addr; b.mask = m;
                    mq.push_back(b);
                end
            end
            if (exp_req && drv_req_ready) begin
                e.addr = m_fetch_pc; e.stale = 1'b0;
                ost.push_back(e);
                m_fetch_pc = (m_fetch_pc + W) % 4096;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic pad_popped(input int n);
        bund_t b;
        b.pc = '1; b.mask = '1;
        while (popped.size() < n) popped.push_back(b);
    endtask

    initial begin
        int k;
        tbl[0] = '{12'h013, 12'h012, 2'b10, 12'h014};
        tbl[1] = '{12'h010, 12'h010, 2'b11, 12'h012};
        tbl[2] = '{12'hFFF, 12'hFFE, 2'b10, 12'h000};
        tbl[3] = '{12'hFFE, 12'hFFE, 2'b11, 12'h000};
        tbl[4] = '{12'h001, 12'h000, 2'b10, 12'h002};

        drv_redirect = 0; drv_rpc = '0; drv_out_ready = 1; drv_req_ready = 1;
        rand_lat = 0; fix_lat = 1; cyc = 0; n_acc = 0;
        redirect_valid = 0; redirect_pc = '0; out_ready = 1; imem_req_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 128'(imem_req_valid), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        rst_n = 1'b1;

        // Streaming with 1-cycle memory
        popped.delete();
        for (k = 0; k < 20 && popped.size() < 4; k++) step();
        chk("seq_len", 128'(popped.size() >= 4), 128'(1));
        pad_popped(4);
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", 128'(popped[i].pc), 128'(2 * i));
            chk("seq_mask", 128'(popped[i].mask), 128'(3));
        end

        // Credit limit with decode stalled
        do_reset();
        drv_out_ready = 0; n_acc = 0;
        repeat (12) step();
        chk("credit_acc", 128'(n_acc), 128'(4));
        chk("credit_count", 128'(count), 128'(4));
        chk("credit_noreq", 128'(imem_req_valid), 128'(0));
        drv_out_ready = 1; step(); drv_out_ready = 0;
        repeat (8) step();
        chk("credit_refill", 128'(n_acc), 128'(5));

        // Redirect table, 3-cycle memory
        do_reset();
        drv_out_ready = 1; fix_lat = 3;
        for (int r = 0; r < 5; r++) begin
            k = 0;
            while (ost.size() != 3 && k < 30) begin step(); k++; end
            chk("rd_setup", 128'(ost.size()), 128'(3));
            drv_redirect = 1; drv_rpc = tbl[r].rpc;
            step();
            drv_redirect = 0;
            popped.delete();
            for (k = 0; k < 40 && popped.size() < 2; k++) step();
            pad_popped(2);
            chk("rd_pc0", 128'(popped[0].pc), 128'(tbl[r].pc0));
            chk("rd_mask0", 128'(popped[0].mask), 128'(tbl[r].m0));
            chk("rd_pc1", 128'(popped[1].pc), 128'(tbl[r].pc1));
            chk("rd_mask1", 128'(popped[1].mask), 128'(3));
        end

        // Redirect, pop and response in one cycle
        do_reset();
        drv_out_ready = 0; fix_lat = 2;
        k = 0;
        while (!(mq.size() >= 1 && mem_q.size() >= 2 && mem_q[0].due <= cyc) && k < 40) begin step(); k++; end
        chk("rpr_setup", 128'(mq.size() >= 1 && mem_q.size() >= 2 && mem_q[0].due <= cyc), 128'(1));
        drv_redirect = 1; drv_rpc = 12'h101; drv_out_ready = 1;
        step();
        drv_redirect = 0;
        chk("rpr_count", 128'(count), 128'(0));
        chk("rpr_valid", 128'(out_valid), 128'(0));
        popped.delete();
        for (k = 0; k < 40 && popped.size() < 1; k++) step();
        pad_popped(1);
        chk("rpr_pc", 128'(popped[0].pc), 128'(12'h100));
        chk("rpr_mask", 128'(popped[0].mask), 128'(2'b10));

        // Reset while requests are outstanding
        do_reset();
        drv_out_ready = 0; fix_lat = 3;
        k = 0;
        while (!(mem_q.size() >= 2 && mq.size() >= 1) && k < 40) begin step(); k++; end
        chk("mrst_setup", 128'(mem_q.size() >= 2 && mq.size() >= 1), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 128'(out_valid), 128'(0));
        chk("mrst_count", 128'(count), 128'(0));
        chk("mrst_req_valid", 128'(imem_req_valid), 128'(0));
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        #1;
        chk("mrst_first_req", 128'(imem_req_valid), 128'(1));
        chk("mrst_first_addr", 128'(imem_req_addr), 128'(0));
        drv_out_ready = 1;
        popped.delete();
        for (k = 0; k < 20 && popped.size() < 1; k++) step();
        pad_popped(1);
        chk("mrst_first_pc", 128'(popped[0].pc), 128'(0));

        // Randomized traffic against the reference model
        do_reset();
        rand_lat = 1;
        for (int n = 0; n < 800; n++) begin
            drv_redirect = ($urandom_range(0, 15) == 0);
            drv_rpc = PC_W'($urandom_range(0, 4095));
            drv_out_ready = ($urandom_range(0, 3) != 0);
            drv_req_ready = ($urandom_range(0, 3) != 0);
            if (n == 400) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2, instructions per bundle; legal values 1, 2, 4.
REQ-002 SHALL have parameter DEPTH, default 4, bundle-queue entries; power of 2, at least 2.
REQ-003 SHALL have parameter PC_W, default 12, width of a word address.
REQ-004 SHALL have parameter RESET_PC, default 0, word address fetched first after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port imem_req_valid, output, 1 bit: fetch request.
REQ-008 SHALL have port imem_req_addr, output, PC_W bits: bundle-aligned word address, low log2(ISSUE_W) bits zero.
REQ-009 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 SHALL have port imem_rsp_valid, input, 1 bit: response data valid; responses return in order, any latency of 1 cycle or more.
REQ-011 SHALL have port imem_rsp_data, input, 32*ISSUE_W bits: bundle; lane 0 is the lowest address, in bits [31:0].
REQ-012 SHALL have port redirect_valid, input, 1 bit: taken branch, jal or jalr from execute.
REQ-013 SHALL have port redirect_pc, input, PC_W bits: redirect target word address, any alignment.
REQ-014 SHALL have port out_valid, output, 1 bit: bundle available to decode.
REQ-015 SHALL have port out_instr, output, 32*ISSUE_W bits: bundle instructions.
REQ-016 SHALL have port out_mask, output, ISSUE_W bits: per-lane valid.
REQ-017 SHALL have port out_pc, output, PC_W bits: aligned word address of lane 0.
REQ-018 SHALL have port out_ready, input, 1 bit: decode consumes the bundle.
REQ-019 SHALL have port count, output, log2(DEPTH)+1 bits: queued bundles.

Function
REQ-020 SHALL keep fetch_pc, a bundle-aligned address, and issue a request (imem_req_valid=1, imem_req_addr=fetch_pc) whenever inflight+count < DEPTH and redirect_valid=0.
REQ-021 SHALL, on imem_req_valid and imem_req_ready, increment inflight and add ISSUE_W to fetch_pc, wrapping modulo 2^PC_W.
REQ-022 SHALL, on imem_rsp_valid with kill=0, enqueue {data, mask, pc}, where pc equals the address of the matching request, and decrement inflight.
REQ-023 SHALL, on imem_rsp_valid with kill>0, discard the data, decrement kill and decrement inflight.
REQ-024 SHALL present the queue head combinationally: out_valid=(count!=0); a pop occurs on out_valid and out_ready.
REQ-025 SHALL allow enqueue and pop in the same cycle with count unchanged; enqueue is never refused, guaranteed by the REQ-020 credit rule.
REQ-026 SHALL, on redirect_valid, in the same edge: flush the queue (count=0), set kill=inflight minus any response discarded that cycle, set fetch_pc=redirect_pc with low bits cleared, and set first_off=redirect_pc low bits with first_pend=1.
REQ-027 SHALL drop a pop requested in a redirect cycle; the flush wins.
REQ-028 SHALL drop a response arriving in a redirect cycle, since it was issued before the redirect.
REQ-029 SHALL hold imem_req_valid=0 in a redirect cycle.
REQ-030 SHALL, when first_pend=1, set the mask of the first live enqueued bundle to lanes >= first_off, then clear first_pend; every other bundle gets an all-ones mask.
REQ-031 SHALL, on a second redirect before the first bundle lands, overwrite first_off and kill per REQ-026.
REQ-032 SHALL limit inflight+count to DEPTH at all times.
REQ-033 SHALL ignore imem_rsp_valid when inflight=0; this condition is a checker error.
REQ-034 SHALL keep out_pc, queue pointers and fetch_pc wrapping mod 2^PC_W and mod DEPTH respectively, with no overflow flag.

Reset
REQ-035 SHALL, while rst_n=0, set fetch_pc=RESET_PC aligned, count=0, inflight=0, kill=0, first_pend=0, out_valid=0, imem_req_valid=0.
REQ-036 SHALL assert the first request on the first clock edge after rst_n rises; reset mid-operation discards all in-flight responses arriving after release, and the memory model must also reset.

Verification
REQ-037 SHALL cover: ISSUE_W=2, 1-cycle memory, out_ready=1 -> out_pc sequence 0,2,4,6, masks 2'b11.
REQ-038 SHALL cover: out_ready=0, DEPTH=4 -> exactly 4 requests accepted, count=4, no fifth request; one pop -> one new request.
REQ-039 SHALL cover: redirect_pc=0x013 with 3 responses in flight, 3-cycle latency -> 3 responses dropped, next out_pc=0x012 with out_mask=2'b10, then 0x014 with 2'b11.
REQ-040 SHALL cover: redirect, pop and response in the same cycle -> count=0 next cycle, response dropped, kill=inflight-1.
REQ-041 SHALL cover: fetch_pc=0xFFE, PC_W=12 -> next request address 0x000.
REQ-042 SHALL cover: rst_n low for 1 cycle while 2 requests are outstanding -> out_valid=0 and count=0 immediately, first request to RESET_PC after release.
